// File: rtl/rvc_asap_pkg.sv
// Shared types and constants for the rvc_asap core: instruction-memory arbiter
// state/owner encodings, I_MEM bounds and the loader address check.
package rvc_asap_pkg;

    localparam logic [31:0] I_MEM_MSB       = 32'h0000_0FFF;
    localparam int          I_ARB_MAX_BURST = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LD_SLOT = 2'd1,
        ST_HALT    = 2'd2
    } t_i_arb_state;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LD    = 2'd2
    } t_i_owner;

    // A loader word access must be aligned and its last byte must lie inside I_MEM.
    function automatic logic i_arb_addr_bad(input logic [31:0] addr, input logic [31:0] msb);
        return (addr[1:0] != 2'b00) || (addr > (msb - 32'd3));
    endfunction

endpackage

// File: rtl/rvc_asap_5pl_i_mem_arb.sv
// Instruction-memory port arbiter: fetch has priority, the loader gets a forced
// slot after a fetch burst, and halt mode hands the whole port to the loader.
module rvc_asap_5pl_i_mem_arb
    import rvc_asap_pkg::*;
#(
    parameter int          MAX_FETCH_BURST = I_ARB_MAX_BURST,
    parameter logic [31:0] MEM_MSB         = I_MEM_MSB
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rsp_valid,
    output logic [31:0] fetch_rsp_data,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    input  logic [3:0]  ld_be,
    output logic        ld_gnt,
    output logic        ld_rsp_valid,
    output logic [31:0] ld_rsp_data,
    output logic        ld_err,
    input  logic        halt_req,
    output logic        halt_ack,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_q
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_FETCH_BURST);

    t_i_arb_state state_r;
    t_i_arb_state state_nxt_s;
    t_i_owner     owner_r;
    t_i_owner     owner_nxt_s;
    logic [7:0]   burst_cnt_r;
    logic [7:0]   burst_cnt_nxt_s;
    logic         ld_err_r;
    logic         halt_ack_r;
    logic         fetch_gnt_s;
    logic         ld_gnt_s;
    logic         forced_s;
    logic         ld_bad_s;
    logic         ld_fwd_s;

    // Grant decision and next state.
    always_comb begin
        fetch_gnt_s = 1'b0;
        ld_gnt_s    = 1'b0;
        state_nxt_s = state_r;
        forced_s    = (burst_cnt_r == BURST_MAX) && ld_req;
        case (state_r)
            ST_RUN: begin
                if (forced_s || !fetch_req) begin
                    ld_gnt_s = ld_req;
                end else begin
                    fetch_gnt_s = 1'b1;
                end
                // The grant that brings the burst to its limit schedules the loader slot.
                if (halt_req) begin
                    state_nxt_s = ST_HALT;
                end else if (fetch_gnt_s && ld_req && (burst_cnt_r == (BURST_MAX - 8'd1))) begin
                    state_nxt_s = ST_LD_SLOT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LD_SLOT: begin
                ld_gnt_s    = ld_req;
                state_nxt_s = halt_req ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                ld_gnt_s    = ld_req;
                state_nxt_s = halt_req ? ST_HALT : ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Fetch burst counter: only counts while the loader is waiting.
    always_comb begin
        burst_cnt_nxt_s = burst_cnt_r;
        if (ld_gnt_s || !ld_req) begin
            burst_cnt_nxt_s = 8'd0;
        end else if (fetch_gnt_s && (burst_cnt_r != BURST_MAX)) begin
            burst_cnt_nxt_s = burst_cnt_r + 8'd1;
        end else begin
            burst_cnt_nxt_s = burst_cnt_r;
        end
    end

    // Memory port mux and read-owner tagging; rejected loader accesses never reach I_MEM.
    always_comb begin
        ld_bad_s    = i_arb_addr_bad(ld_addr, MEM_MSB);
        ld_fwd_s    = ld_gnt_s && !ld_bad_s;
        mem_addr    = fetch_addr;
        mem_we      = 1'b0;
        mem_wdata   = 32'h0000_0000;
        mem_be      = 4'h0;
        owner_nxt_s = OWN_NONE;
        if (ld_fwd_s) begin
            mem_addr    = ld_addr;
            mem_we      = ld_we;
            mem_wdata   = ld_wdata;
            mem_be      = ld_we ? ld_be : 4'hF;
            owner_nxt_s = ld_we ? OWN_NONE : OWN_LD;
        end else if (fetch_gnt_s) begin
            mem_be      = 4'hF;
            owner_nxt_s = OWN_FETCH;
        end else begin
            mem_be      = 4'h0;
            owner_nxt_s = OWN_NONE;
        end
    end

    // Arbiter state; clearing owner on reset drops any read in flight.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            owner_r     <= OWN_NONE;
            burst_cnt_r <= 8'd0;
            ld_err_r    <= 1'b0;
            halt_ack_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
            ld_err_r    <= ld_gnt_s && ld_bad_s;
            halt_ack_r  <= (state_r == ST_HALT) && halt_req;
        end
    end

    assign fetch_gnt       = fetch_gnt_s;
    assign ld_gnt          = ld_gnt_s;
    assign fetch_rsp_valid = (owner_r == OWN_FETCH);
    assign ld_rsp_valid    = (owner_r == OWN_LD);
    assign fetch_rsp_data  = mem_q;
    assign ld_rsp_data     = mem_q;
    assign ld_err          = ld_err_r;
    assign halt_ack        = halt_ack_r;

endmodule

// File: tb/tb_rvc_asap_5pl_i_mem_arb.sv
// Bench for rvc_asap_5pl_i_mem_arb: I_MEM model, per-cycle grant checks and a
// response scoreboard fed from an independent expected-memory image.
module tb_rvc_asap_5pl_i_mem_arb;

    localparam logic [31:0] MSB = 32'h0000_0FFF;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_data;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic [3:0]  ld_be;
    logic        ld_gnt;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_data;
    logic        ld_err;
    logic        halt_req;
    logic        halt_ack;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_q;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_wr [int];
    logic [31:0] fq [$];
    logic [31:0] lq [$];
    logic        f_pend = 1'b0;
    logic        l_pend = 1'b0;
    logic        e_pend = 1'b0;
    int          checks = 0;
    int          failures = 0;

    rvc_asap_5pl_i_mem_arb #(.MAX_FETCH_BURST(8), .MEM_MSB(MSB)) dut (
        .clock(clock), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_be(ld_be),
        .ld_gnt(ld_gnt), .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_err(ld_err),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int idx);
        return 32'hC0DE_0000 ^ (32'(idx) * 32'h0001_0101);
    endfunction

    function automatic logic [31:0] exp_word(input int idx);
        return exp_wr.exists(idx) ? exp_wr[idx] : init_word(idx);
    endfunction

    // Synchronous-read I_MEM with byte enables, reloaded while reset is held.
    always @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_q <= mem[mem_addr[11:2]];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_rsp();
        logic [31:0] d;
        check_eq("fetch_rsp_valid", 32'(fetch_rsp_valid), 32'(f_pend));
        if (f_pend) begin
            d = fq.pop_front();
            if (fetch_rsp_valid) check_eq("fetch_rsp_data", fetch_rsp_data, d);
        end
        check_eq("ld_rsp_valid", 32'(ld_rsp_valid), 32'(l_pend));
        if (l_pend) begin
            d = lq.pop_front();
            if (ld_rsp_valid) check_eq("ld_rsp_data", ld_rsp_data, d);
        end
        check_eq("ld_err", 32'(ld_err), 32'(e_pend));
        f_pend = 1'b0;
        l_pend = 1'b0;
        e_pend = 1'b0;
    endtask

    // One clock cycle: check last cycle's responses, drive, check grants/port, queue expectations.
    task automatic cyc(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                       input logic [31:0] la, input logic [31:0] lwd, input logic [3:0] lbe,
                       input logic hr, input logic efg, input logic elg, input logic eha);
        logic        bad;
        logic        wr_ok;
        logic [31:0] w;
        @(negedge clock);
        check_rsp();
        fetch_req = fr; fetch_addr = fa;
        ld_req = lr; ld_we = lwe; ld_addr = la; ld_wdata = lwd; ld_be = lbe;
        halt_req = hr;
        #1;
        bad   = (la[1:0] != 2'b00) || (la > (MSB - 32'd3));
        wr_ok = elg && lwe && !bad;
        check_eq("fetch_gnt", 32'(fetch_gnt), 32'(efg));
        check_eq("ld_gnt", 32'(ld_gnt), 32'(elg));
        check_eq("halt_ack", 32'(halt_ack), 32'(eha));
        check_eq("mem_we", 32'(mem_we), 32'(wr_ok));
        check_eq("mem_addr", mem_addr, (elg && !bad) ? la : fa);
        if (wr_ok) begin
            check_eq("mem_wdata", mem_wdata, lwd);
            check_eq("mem_be", 32'(mem_be), 32'(lbe));
            w = exp_word(int'(la[11:2]));
            for (int b = 0; b < 4; b++)
                if (lbe[b]) w[8*b +: 8] = lwd[8*b +: 8];
            exp_wr[int'(la[11:2])] = w;
        end else if (!efg && !elg) begin
            check_eq("mem_be_idle", 32'(mem_be), 32'h0);
        end
        if (efg) begin
            fq.push_back(exp_word(int'(fa[11:2])));
            f_pend = 1'b1;
        end
        if (elg && !lwe && !bad) begin
            lq.push_back(exp_word(int'(la[11:2])));
            l_pend = 1'b1;
        end
        e_pend = elg && bad;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_fetch_rsp_valid"}, 32'(fetch_rsp_valid), 32'h0);
        check_eq({tag, "_ld_rsp_valid"}, 32'(ld_rsp_valid), 32'h0);
        check_eq({tag, "_ld_err"}, 32'(ld_err), 32'h0);
        check_eq({tag, "_halt_ack"}, 32'(halt_ack), 32'h0);
        check_eq({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        check_eq({tag, "_mem_be"}, 32'(mem_be), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = 32'h0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0; ld_be = 4'h0;
        halt_req = 1'b0;
        repeat (2) @(negedge clock);
        check_quiet("reset");
        check_eq("reset_fetch_gnt", 32'(fetch_gnt), 32'h0);
        check_eq("reset_ld_gnt", 32'(ld_gnt), 32'h0);
        rst_n = 1'b1;

        // Fetch at 0x10 granted, then reset lands while its read is in flight.
        cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        fetch_req = 1'b0;
        f_pend = 1'b0;
        fq.delete();
        @(negedge clock);
        check_quiet("midrst");
        #1 rst_n = 1'b1;
        idle();

        // Fetch-only stream, then a loader read while fetch is idle.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();

        // Starvation guard: 8 fetch grants, one loader slot, fetch resumes.
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 32'h40 + 32'(4 * i), (i < 9), 1'b0, 32'h100, 32'h0, 4'h0, 1'b0,
                (i != 8), (i == 8), 1'b0);
        idle();

        // Halt entry with fetch still requesting.
        cyc(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Full write, readback, partial write, readback.
        cyc(1'b1, 32'h50, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'h50, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'h50, 1'b1, 1'b1, 32'h20, 32'h0000_CAFE, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'h50, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        // Rejected accesses: misaligned, at the top edge, out-of-range write.
        cyc(1'b1, 32'h50, 1'b1, 1'b0, 32'h22, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'h50, 1'b1, 1'b0, MSB - 32'd1, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'h50, 1'b1, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1);
        // Last valid word, then release halt with that read in flight.
        cyc(1'b1, 32'h50, 1'b1, 1'b0, MSB - 32'd3, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        idle();

        check_eq("fetch_queue_empty", 32'(fq.size()), 32'h0);
        check_eq("ld_queue_empty", 32'(lq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
